// File: rtl/wait_handshake_responder_pkg.sv
// wait_handshake_responder_pkg: state encodings, data type and wait-counter width
// shared by the responder, its wait counter and its handshake interface.
package wait_handshake_responder_pkg;
   typedef enum logic signed [31:0] {
      ST_IDLE    = 32'sd0,
      ST_WAIT    = 32'sd1,
      ST_RESPOND = 32'sd2
   } state_e;
   typedef logic signed [31:0] data_t;
   localparam int CNT_W = 8;
endpackage

// File: rtl/wait_handshake_responder_if.sv
// wait_handshake_responder_if: request/response handshake bundle between initiator and responder.
interface wait_handshake_responder_if;
   import wait_handshake_responder_pkg::*;
   logic        req_valid;
   data_t       req_data;
   logic        req_ready;
   logic        rsp_valid;
   data_t       rsp_data;
   logic        rsp_ready;
   logic [15:0] rsp_count;
   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_count
   );
   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_count
   );
endinterface

// File: rtl/wait_handshake_responder_wait_counter.sv
// wait_counter: loadable down-counter that flags when the next decrement reaches zero.
module wait_counter
   import wait_handshake_responder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_dec_zero
);
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d, w_dec_val;
   assign w_dec_val  = r_cnt_q - CNT_W'(1);
   assign o_dec_zero = (w_dec_val == '0);
   always_comb r_cnt_d = i_load ? i_load_val : i_dec ? w_dec_val : r_cnt_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_cnt_q <= '0;
      else        r_cnt_q <= r_cnt_d;
endmodule

// File: rtl/wait_handshake_responder.sv
// wait_handshake_responder: accepts one request, waits LATENCY cycles, then holds
// captured+ADDEND as a response until the initiator takes it.
module wait_handshake_responder
   import wait_handshake_responder_pkg::*;
#(
   parameter int        LATENCY = 4,
   parameter int signed ADDEND  = 1
) (
   input logic                        clk,
   input logic                        reset,
   wait_handshake_responder_if.slave  bus
);
   state_e      r_state_q, r_state_d, r_next_q, r_next_d;
   data_t       r_data_q, r_data_d;
   logic [15:0] r_count_q, r_count_d;
   logic        w_load, w_dec, w_dec_zero;
   wait_counter u_wait_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (CNT_W'(LATENCY)),
      .i_dec      (w_dec),
      .o_dec_zero (w_dec_zero)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state_q <= ST_IDLE;
         r_next_q  <= ST_IDLE;
         r_data_q  <= '0;
         r_count_q <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_next_q  <= r_next_d;
         r_data_q  <= r_data_d;
         r_count_q <= r_count_d;
      end
   always_comb begin
      r_state_d = r_state_q;
      r_next_d  = r_next_q;
      r_data_d  = r_data_q;
      r_count_d = r_count_q;
      w_load    = 1'b0;
      w_dec     = 1'b0;
      case (r_state_q)
         ST_IDLE: if (bus.req_valid) begin
            r_data_d  = bus.req_data;
            w_load    = 1'b1;
            r_next_d  = ST_RESPOND;
            r_state_d = (LATENCY == 0) ? ST_RESPOND : ST_WAIT;
         end
         ST_WAIT: begin
            w_dec = 1'b1;
            if (w_dec_zero) r_state_d = r_next_q;
         end
         ST_RESPOND: if (bus.rsp_ready) begin
            r_count_d = r_count_q + 16'd1;
            r_state_d = ST_IDLE;
         end
         default: r_state_d = ST_IDLE;
      endcase
   end
   // handshake outputs depend on state only, never on the inputs
   assign bus.req_ready = (r_state_q == ST_IDLE);
   assign bus.rsp_valid = (r_state_q == ST_RESPOND);
   assign bus.rsp_data  = (r_state_q == ST_RESPOND) ? r_data_q + data_t'(ADDEND) : '0;
   assign bus.rsp_count = r_count_q;
endmodule

// File: tb/tb_wait_handshake_responder.sv
// tb_wait_handshake_responder: table vectors plus corner-case sequences for the
// LATENCY=4 responder, and a short LATENCY=0 check on a second instance.
module tb_wait_handshake_responder;
   import wait_handshake_responder_pkg::*;
   typedef struct { data_t d; data_t e; int dly; } vec_t;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          cyc = 0, acc = 0, n_tests = 0, n_fail = 0;
   logic        prev_v = 1'b0;
   logic [15:0] exp_cnt = 16'd0;
   data_t       q4[$];
   vec_t        tbl[6];
   wait_handshake_responder_if b4 ();
   wait_handshake_responder_if b0 ();
   wait_handshake_responder #(.LATENCY(4), .ADDEND(1)) dut4 (.clk(clk), .reset(reset), .bus(b4));
   wait_handshake_responder #(.LATENCY(0), .ADDEND(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
   endtask
   task automatic send(input data_t d, input data_t e);
      int k;
      @(posedge clk); #1;
      q4.push_back(e);
      b4.req_valid = 1'b1;
      b4.req_data  = d;
      k = 0;
      do begin @(negedge clk); k++; end while (!b4.req_ready && k < 20);
      if (!b4.req_ready) timeout("send_accept");
      @(posedge clk); #1;
      b4.req_valid = 1'b0;
   endtask
   task automatic wait_valid();
      int k;
      k = 0;
      while (!b4.rsp_valid && k < 20) begin @(negedge clk); k++; end
      if (!b4.rsp_valid) timeout("wait_rsp_valid");
   endtask
   // scoreboard and first-response latency monitor for the LATENCY=4 instance
   always @(negedge clk) begin
      if (!reset) prev_v = 1'b0;
      else begin
         if (b4.rsp_valid && !prev_v) chk("latency", cyc - acc, 4);
         prev_v = b4.rsp_valid;
         if (b4.req_valid && b4.req_ready) acc = cyc + 1;
         if (b4.rsp_valid && b4.rsp_ready) begin
            if (q4.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard: response %0h with no expected entry", b4.rsp_data);
            end else chk("scoreboard", b4.rsp_data, q4.pop_front());
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: run did not end (%0d tests, %0d failed)", n_tests, n_fail);
      $fatal(1, "watchdog");
   end
   initial begin
      int a[3];
      int j;
      tbl[0] = '{32'sd0, 32'sd1, 0};
      tbl[1] = '{-32'sd1, 32'sd0, 2};
      tbl[2] = '{32'sh7FFFFFFF, 32'sh80000000, 0};
      tbl[3] = '{32'sh80000000, 32'sh80000001, 1};
      tbl[4] = '{32'sd12345, 32'sd12346, 3};
      tbl[5] = '{-32'sd100, -32'sd99, 0};
      b4.req_valid = 1'b0; b4.req_data = '0; b4.rsp_ready = 1'b0;
      b0.req_valid = 1'b0; b0.req_data = '0; b0.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_req_ready", b4.req_ready, 1'b1);
      chk1("rst_rsp_valid", b4.rsp_valid, 1'b0);
      chk("rst_rsp_data", b4.rsp_data, 0);
      chk("rst_rsp_count", 32'(b4.rsp_count), 0);
      chk1("rst0_req_ready", b0.req_ready, 1'b1);
      chk1("rst0_rsp_valid", b0.rsp_valid, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      // reset in the middle of WAIT abandons the transaction
      b4.rsp_ready = 1'b1; b4.req_valid = 1'b1; b4.req_data = 32'sd20;
      @(posedge clk); #1 b4.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk1("midwait_req_ready", b4.req_ready, 1'b1);
      chk1("midwait_rsp_valid", b4.rsp_valid, 1'b0);
      chk("midwait_rsp_data", b4.rsp_data, 0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (8) begin @(negedge clk); chk1("abandon_no_rsp", b4.rsp_valid, 1'b0); end
      chk("abandon_count", 32'(b4.rsp_count), 32'(exp_cnt));
      // req_data=10 accepted at edge 0, response after edge 4, done after edge 5
      send(32'sd10, 32'sd11);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk1("lat4_rsp_valid", b4.rsp_valid, i == 4);
      end
      chk("lat4_rsp_data", b4.rsp_data, 32'sd11);
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk("lat4_count", 32'(b4.rsp_count), 32'(exp_cnt));
      chk1("lat4_idle", b4.req_ready, 1'b1);
      // backpressure with ignored request pulses
      @(posedge clk); #1 b4.rsp_ready = 1'b0;
      send(-32'sd5, -32'sd4);
      wait_valid();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 b4.req_valid = (i % 2 == 0);
         @(negedge clk);
         chk1("bp_rsp_valid", b4.rsp_valid, 1'b1);
         chk("bp_rsp_data", b4.rsp_data, -32'sd4);
         chk1("bp_req_ready", b4.req_ready, 1'b0);
      end
      @(posedge clk); #1 b4.req_valid = 1'b0; b4.rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      exp_cnt++;
      chk("bp_count", 32'(b4.rsp_count), 32'(exp_cnt));
      // table vectors with varied response stall
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 b4.rsp_ready = 1'b0;
         send(tbl[i].d, tbl[i].e);
         wait_valid();
         chk("tbl_rsp_data", b4.rsp_data, tbl[i].e);
         repeat (tbl[i].dly) @(posedge clk);
         @(posedge clk); #1 b4.rsp_ready = 1'b1;
         @(posedge clk);
         exp_cnt++;
         @(negedge clk);
         chk("tbl_count", 32'(b4.rsp_count), 32'(exp_cnt));
      end
      // response counter wraps 65535 -> 0
      @(negedge clk);
      force dut4.r_count_q = 16'hFFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      release dut4.r_count_q;
      exp_cnt = 16'hFFFF;
      send(-32'sd2, -32'sd1);
      wait_valid();
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      chk("count_wrap", 32'(b4.rsp_count), 32'(exp_cnt));
      // back-to-back acceptances with rsp_ready tied high
      @(posedge clk); #1;
      repeat (3) q4.push_back(32'sd501);
      b4.rsp_ready = 1'b1; b4.req_valid = 1'b1; b4.req_data = 32'sd500;
      for (int k = 0; k < 3; k++) begin
         j = 0;
         do begin @(negedge clk); j++; end while (!b4.req_ready && j < 20);
         if (!b4.req_ready) timeout("b2b_accept");
         a[k] = cyc + 1;
         @(posedge clk); #1;
         if (k == 2) b4.req_valid = 1'b0;
      end
      chk("b2b_spacing_1", a[1] - a[0], 6);
      chk("b2b_spacing_2", a[2] - a[1], 6);
      wait_valid();
      @(posedge clk);
      exp_cnt += 16'd3;
      @(negedge clk);
      chk("b2b_count", 32'(b4.rsp_count), 32'(exp_cnt));
      // LATENCY=0: response right after the accepting edge
      @(posedge clk); #1;
      b0.rsp_ready = 1'b1; b0.req_valid = 1'b1; b0.req_data = -32'sd1;
      @(negedge clk);
      chk1("lat0_req_ready", b0.req_ready, 1'b1);
      @(posedge clk); #1 b0.req_valid = 1'b0;
      @(negedge clk);
      chk1("lat0_rsp_valid", b0.rsp_valid, 1'b1);
      chk("lat0_rsp_data", b0.rsp_data, 0);
      @(posedge clk); @(negedge clk);
      chk("lat0_count", 32'(b0.rsp_count), 1);
      chk1("lat0_done", b0.rsp_valid, 1'b0);
      chk("sb_drained", q4.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
